// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command sequencer for a W-bit accumulator ALU.
// Commands are popped one at a time and executed against an internal accumulator.
// Each result is returned over a valid/ready handshake.
// Optional feature macro: ALU_SEQ_DIV_EN builds the W-cycle restoring divider for DIV.
// Without the macro, DIV behaves as NOOP.
module alu_cmd_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [3:0]   res_op,
    output logic         has_last_res,
    output logic         busy
);

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_RESET = 4'b1111;

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;

    state_t         state, state_nxt;

    logic [3:0]     fifo_op [DEPTH];
    logic [W-1:0]   fifo_a  [DEPTH];
    logic [W-1:0]   fifo_b  [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty, push, pop;

    logic [W-1:0]   acc;
    logic [3:0]     op_q;
    logic [W-1:0]   x_q, y_q;
    logic [W-1:0]   x_sel, y_sel;
    logic           head_is_div;

    logic [W-1:0]   alu_res;
    logic           alu_wr;
    logic           finish;
    logic [W-1:0]   fin_res;
    logic           fin_wr;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = ~full & ~clear;
    assign push      = cmd_valid & cmd_ready;
    assign res_valid = (state == RESP);
    assign busy      = (state != IDLE) | ~empty;

    // First operation takes both operands from the command; later ones chain off acc.
    assign x_sel = has_last_res ? acc : fifo_a[rd_ptr];
    assign y_sel = has_last_res ? fifo_a[rd_ptr] : fifo_b[rd_ptr];

`ifdef ALU_SEQ_DIV_EN
    localparam int          CW       = $clog2(W + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(W);

    logic [CW-1:0] div_cnt;
    logic [W-1:0]  rem_q, quo_q;
    logic [W:0]    div_shift, div_diff;
    logic          div_done;

    assign head_is_div = (fifo_op[rd_ptr] == OP_DIV);
    assign div_shift   = {rem_q, quo_q[W-1]};
    assign div_diff    = div_shift - {1'b0, y_q};
    assign div_done    = (state == DIV) && (div_cnt == DIV_LAST);

    // Restoring divider: one quotient bit per cycle; y==0 never underflows, giving all ones.
    always_ff @(posedge clk) begin
        if (pop) begin
            rem_q   <= '0;
            quo_q   <= x_sel;
            div_cnt <= '0;
        end else if (state == DIV && div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
            if (!div_diff[W]) begin
                rem_q <= div_diff[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= div_shift[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    assign finish  = (state == EXEC) | div_done;
    assign fin_res = div_done ? quo_q : alu_res;
    assign fin_wr  = div_done | alu_wr;
`else
    assign head_is_div = 1'b0;
    assign finish      = (state == EXEC);
    assign fin_res     = alu_res;
    assign fin_wr      = alu_wr;
`endif

    // Single-cycle ALU; anything not listed (including DIV when the divider is absent) acts as NOOP.
    always_comb begin
        alu_res = acc;
        alu_wr  = 1'b0;
        case (op_q)
            OP_ADD:  begin alu_res = x_q + y_q; alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = x_q - y_q; alu_wr = 1'b1; end
            OP_MULT: begin alu_res = x_q * y_q; alu_wr = 1'b1; end
            OP_AND:  begin alu_res = x_q & y_q; alu_wr = 1'b1; end
            OP_OR:   begin alu_res = x_q | y_q; alu_wr = 1'b1; end
            OP_XOR:  begin alu_res = x_q ^ y_q; alu_wr = 1'b1; end
            OP_NOT:  begin alu_res = ~x_q;      alu_wr = 1'b1; end
            OP_RESET: alu_res = '0;
            default: ;
        endcase
    end

    // Next-state and FIFO pop decision.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = head_is_div ? DIV : EXEC;
                end
            end
            EXEC: state_nxt = RESP;
`ifdef ALU_SEQ_DIV_EN
            DIV:  if (div_done) state_nxt = RESP;
`endif
            RESP: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; clear aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // FIFO storage; push already excludes clear through cmd_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr] <= cmd_op;
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
        end
    end

    // FIFO pointers, operand latch, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            acc          <= '0;
            has_last_res <= 1'b0;
            res_data     <= '0;
            res_op       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                op_q   <= fifo_op[rd_ptr];
                x_q    <= x_sel;
                y_q    <= y_sel;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (finish) begin
                res_data <= fin_res;
                res_op   <= op_q;
                if (op_q == OP_RESET) begin
                    acc          <= '0;
                    has_last_res <= 1'b0;
                end else if (fin_wr) begin
                    acc          <= fin_res;
                    has_last_res <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: vector table plus stall and abort sequences.
// Expected results go into a scoreboard queue when a command is sent and are
// compared when the DUT presents the result.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_RESET = 4'b1111;

    logic         clk = 1'b0;
    logic         clear, cmd_valid, cmd_ready, res_valid, res_ready, has_last_res, busy;
    logic [3:0]   cmd_op, res_op;
    logic [W-1:0] cmd_a, cmd_b, res_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         clr;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic         exp_hlr;
        int           exp_lat;
    } vec_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .clear        (clear),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_op       (res_op),
        .has_last_res (has_last_res),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        chk("cmd_ready_during_clear", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_push", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("res_valid_wait", {31'b0, res_valid}, 32'd1);
    endtask

    task automatic check_output(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got result %h with nothing expected", name, res_data);
        end else begin
            e = sb.pop_front();
            chk({name, "_data"}, {16'b0, res_data}, {16'b0, e.data});
            chk({name, "_op"}, {28'b0, res_op}, {28'b0, e.op});
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int accepted;
        int got;
        int cyc;
        int seen;
        int div_lat;
        vec_t v;
        exp_t e;

        clear     = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;

`ifdef ALU_SEQ_DIV_EN
        div_lat = W + 2;
`else
        div_lat = 2;
`endif

        // clr, op, a, b, expected result, expected has_last_res, expected latency
        vecs.push_back('{1'b1, OP_ADD,   16'd1,     16'd1,     16'd2,     1'b1, 2});
        vecs.push_back('{1'b0, OP_ADD,   16'd1,     16'd0,     16'd3,     1'b1, 2});
        vecs.push_back('{1'b1, OP_SUB,   16'd15,    16'd1,     16'd14,    1'b1, 2});
        vecs.push_back('{1'b0, OP_SUB,   16'd1,     16'd0,     16'd13,    1'b1, 2});
        vecs.push_back('{1'b0, OP_SUB,   16'd20,    16'd0,     16'hFFF9,  1'b1, 2});
        vecs.push_back('{1'b1, OP_MULT,  16'd2,     16'd2,     16'd4,     1'b1, 2});
        vecs.push_back('{1'b0, OP_MULT,  16'h8000,  16'd0,     16'h0000,  1'b1, 2});
        vecs.push_back('{1'b1, OP_XOR,   16'hC000,  16'hF000,  16'h3000,  1'b1, 2});
        vecs.push_back('{1'b0, OP_RESET, 16'h1234,  16'h5678,  16'h0000,  1'b0, 2});
        vecs.push_back('{1'b0, OP_NOT,   16'h000F,  16'h0000,  16'hFFF0,  1'b1, 2});
        vecs.push_back('{1'b1, OP_AND,   16'h0FF0,  16'h00FF,  16'h00F0,  1'b1, 2});
        vecs.push_back('{1'b0, OP_OR,    16'h1234,  16'h0000,  16'h12F4,  1'b1, 2});
        vecs.push_back('{1'b0, OP_NOOP,  16'h5555,  16'hAAAA,  16'h12F4,  1'b1, 2});
        vecs.push_back('{1'b0, 4'b1010,  16'h5555,  16'h0000,  16'h12F4,  1'b1, 2});
`ifdef ALU_SEQ_DIV_EN
        vecs.push_back('{1'b1, OP_DIV,   16'd100,   16'd7,     16'd14,    1'b1, div_lat});
        vecs.push_back('{1'b1, OP_DIV,   16'd5,     16'd0,     16'hFFFF,  1'b1, div_lat});
`else
        vecs.push_back('{1'b1, OP_DIV,   16'd100,   16'd7,     16'd0,     1'b0, div_lat});
        vecs.push_back('{1'b1, OP_DIV,   16'd5,     16'd0,     16'd0,     1'b0, div_lat});
`endif

        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
        chk("reset_res_data", {16'b0, res_data}, 32'd0);
        chk("reset_res_op", {28'b0, res_op}, 32'd0);
        chk("reset_has_last_res", {31'b0, has_last_res}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Table-driven single commands.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.clr) do_clear();
            send_cmd(v.op, v.a, v.b);
            e.op   = v.op;
            e.data = v.exp_data;
            sb.push_back(e);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i), lat, v.exp_lat);
            chk($sformatf("vec%0d_has_last_res", i), {31'b0, has_last_res}, {31'b0, v.exp_hlr});
            check_output($sformatf("vec%0d", i));
            handshake();
        end

        // Consumer stall: FIFO fills behind the command held in RESP.
        do_clear();
        res_ready = 1'b0;
        accepted  = 0;
        cyc       = 0;
        cmd_op    = OP_ADD;
        cmd_a     = 16'd1;
        cmd_b     = 16'd0;
        cmd_valid = 1'b1;
        while (accepted < 5 && cyc < 50) begin
            if (cmd_ready) begin
                tick();
                accepted++;
                e.op   = OP_ADD;
                e.data = accepted[W-1:0];
                sb.push_back(e);
            end else begin
                tick();
            end
            cyc++;
        end
        chk("stall_accepted", accepted, 5);
        chk("stall_cmd_ready_full", {31'b0, cmd_ready}, 32'd0);
        tick();
        tick();
        chk("stall_cmd_ready_held", {31'b0, cmd_ready}, 32'd0);
        chk("stall_busy", {31'b0, busy}, 32'd1);
        chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 200) begin
            if (res_valid) begin
                check_output($sformatf("stall%0d", got));
                got++;
            end
            tick();
            cyc++;
        end
        res_ready = 1'b0;
        chk("stall_results", got, 5);
        repeat (5) tick();
        chk("stall_drained_res_valid", {31'b0, res_valid}, 32'd0);
        chk("stall_drained_busy", {31'b0, busy}, 32'd0);

        // Abort: clear at the 5th divider iteration with another command queued.
        do_clear();
        send_cmd(OP_DIV, 16'd100, 16'd7);
        send_cmd(OP_ADD, 16'd1, 16'd1);
        repeat (4) tick();
        clear     = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 16'd9;
        cmd_b     = 16'd9;
        cmd_valid = 1'b1;
        #1;
        chk("abort_cmd_ready_in_clear", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("abort_res_valid", {31'b0, res_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_has_last_res", {31'b0, has_last_res}, 32'd0);
        chk("abort_res_data", {16'b0, res_data}, 32'd0);
        chk("abort_res_op", {28'b0, res_op}, 32'd0);
        chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (res_valid || busy) seen++;
        end
        chk("abort_no_activity", seen, 0);
        send_cmd(OP_NOOP, 16'h7777, 16'h8888);
        e.op   = OP_NOOP;
        e.data = 16'd0;
        sb.push_back(e);
        wait_result(lat);
        chk("abort_noop_latency", lat, 2);
        chk("abort_noop_has_last_res", {31'b0, has_last_res}, 32'd0);
        check_output("abort_noop");
        handshake();

        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
